// File: rtl/ifu_pc_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : ifu_pc_gen_if
// Description : Instruction-bus request/response bundle used by ifu_pc_gen.
//               master : fetch-request generator (drives request, sees ready
//                        and in-order response valid)
//               slave  : instruction bus side
//   req_valid  master->slave  request valid
//   req_addr   master->slave  word-aligned request address
//   req_ready  slave->master  bus accepts request
//   rsp_valid  slave->master  in-order read response valid
// Revision    : 1.0 - initial release
// ============================================================================
interface ifu_pc_gen_if #(
  parameter int AW = 32
);
  logic          req_valid;
  logic [AW-1:0] req_addr;
  logic          req_ready;
  logic          rsp_valid;

  modport master (
    output req_valid,
    output req_addr,
    input  req_ready,
    input  rsp_valid
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    output req_ready,
    output rsp_valid
  );
endinterface
`default_nettype wire

// File: rtl/ifu_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : ifu_pc_gen
// Description : Fetch-request generator at the head of the instruction fetch
//               unit. Holds the fetch PC, issues single-beat read requests,
//               pushes every accepted address into the downstream fetch
//               address FIFO, flushes that FIFO on redirect and counts stale
//               in-flight responses so they are dropped.
// Ports       :
//   i_clk, i_rstn        clock, asynchronous active-low reset
//   i_redirect(_pc)      single-cycle redirect pulse and its target
//   i_stall              decode backpressure, blocks new requests
//   bus (master)         req_valid/req_addr/req_ready/rsp_valid
//   o_fifo_wen/_wdata    push of the accepted request address
//   o_fifo_flush         flush of the address FIFO (= i_redirect)
//   i_fifo_cnt           address FIFO occupancy
//   o_rsp_accept/_drop   classification of the current response
//   o_stale_cnt          stale responses still expected
// Options     : IFU_PC_GEN_PERF_EN adds o_perf_drop_cnt, a saturating count
//               of dropped responses.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_pc_gen #(
  parameter int            AW              = 32,
  parameter logic [AW-1:0] RESET_PC        = '0,
  parameter int            FIFO_DEPTH      = 16,
  parameter int            MAX_OUTSTANDING = 4
) (
  input  wire                                   i_clk,
  input  wire                                   i_rstn,
  input  wire                                   i_redirect,
  input  wire  [AW-1:0]                         i_redirect_pc,
  input  wire                                   i_stall,
  ifu_pc_gen_if.master                          bus,
  output logic                                  o_fifo_wen,
  output logic [AW-1:0]                         o_fifo_wdata,
  output logic                                  o_fifo_flush,
  input  wire  [$clog2(FIFO_DEPTH):0]           i_fifo_cnt,
  output logic                                  o_rsp_accept,
  output logic                                  o_rsp_drop,
  output logic [$clog2(MAX_OUTSTANDING):0]      o_stale_cnt
`ifdef IFU_PC_GEN_PERF_EN
  ,
  output logic [31:0]                           o_perf_drop_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(MAX_OUTSTANDING) + 1;
  // Wide enough to hold stale + fifo occupancy without overflow.
  localparam int TW = ((CW > SW) ? CW : SW) + 1;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          pending_q, pending_d;
  logic [SW-1:0] stale_q, stale_d;

  logic [AW-1:0] redirect_addr;
  logic [AW-1:0] req_addr;
  logic          req_valid;
  logic          handshake;
  logic          rsp_valid;
  logic [TW-1:0] outstanding;
  logic          below_limit;
  logic          unused_pc_lsbs;

  assign rsp_valid      = bus.rsp_valid;
  assign redirect_addr  = {i_redirect_pc[AW-1:2], 2'b00};
  assign unused_pc_lsbs = ^i_redirect_pc[1:0];

  // Old-path stale responses plus current-path FIFO entries: everything that
  // has been issued and not yet answered.
  assign outstanding = TW'(stale_q) + TW'(i_fifo_cnt);
  assign below_limit = (outstanding < TW'(MAX_OUTSTANDING));

  // Combinational so a redirect retargets a pending request in-cycle.
  assign req_addr = i_redirect ? redirect_addr : pc_q;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_d    = pending_q;
    stale_d      = stale_q;
    req_valid    = 1'b0;
    o_rsp_accept = 1'b0;
    o_rsp_drop   = 1'b0;

    case (state_q)
      S_BOOT: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        // A pending request stays valid regardless of stall or limit.
        req_valid = pending_q | (~i_stall & below_limit);
        if (i_stall && !pending_q) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (!i_stall) begin
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_BOOT;
      end
    endcase

    handshake = req_valid & bus.req_ready;

    if (handshake) begin
      pc_d      = req_addr + AW'(4);
      pending_d = 1'b0;
    end else begin
      if (req_valid) begin
        pending_d = 1'b1;
      end
      if (i_redirect) begin
        pc_d = redirect_addr;
      end
    end

    if (i_redirect) begin
      // Every FIFO entry becomes stale; a response this cycle retires the
      // oldest outstanding request whichever path it belongs to.
      o_rsp_drop = rsp_valid;
      stale_d    = SW'(outstanding - TW'(rsp_valid && (outstanding != '0)));
    end else if (rsp_valid) begin
      if (stale_q != '0) begin
        o_rsp_drop = 1'b1;
        stale_d    = stale_q - SW'(1);
      end else begin
        o_rsp_accept = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q   <= S_BOOT;
      pc_q      <= RESET_PC;
      pending_q <= 1'b0;
      stale_q   <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
      stale_q   <= stale_d;
    end
  end

  assign bus.req_valid = req_valid;
  assign bus.req_addr  = req_addr;
  assign o_fifo_wen    = handshake;
  assign o_fifo_wdata  = req_addr;
  assign o_fifo_flush  = i_redirect;
  assign o_stale_cnt   = stale_q;

`ifdef IFU_PC_GEN_PERF_EN
  logic [31:0] perf_drop_cnt_q, perf_drop_cnt_d;

  always_comb begin
    perf_drop_cnt_d = perf_drop_cnt_q;
    if (o_rsp_drop && (perf_drop_cnt_q != 32'hFFFF_FFFF)) begin
      perf_drop_cnt_d = perf_drop_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      perf_drop_cnt_q <= '0;
    end else begin
      perf_drop_cnt_q <= perf_drop_cnt_d;
    end
  end

  assign o_perf_drop_cnt = perf_drop_cnt_q;
`endif

`ifndef SYNTHESIS
  a_outstanding_limit: assert property (@(posedge i_clk) disable iff (!i_rstn)
    outstanding <= TW'(MAX_OUTSTANDING));
  a_rsp_without_outstanding: assert property (@(posedge i_clk) disable iff (!i_rstn)
    !(rsp_valid && (outstanding == '0)));
`endif

endmodule
`default_nettype wire

// File: tb/tb_ifu_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_pc_gen
// Description : Self-checking bench for ifu_pc_gen. The reference keeps every
//               issued request in a queue tagged with the redirect epoch it
//               was issued in; a response is stale when its tag is older than
//               the current epoch. The address FIFO and instruction bus are
//               modelled as queues fed by the DUT outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_pc_gen;
  localparam int AW  = 32;
  localparam int MAX = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          stall;
  logic          fifo_wen;
  logic [AW-1:0] fifo_wdata;
  logic          fifo_flush;
  logic [4:0]    fifo_cnt;
  logic          rsp_accept;
  logic          rsp_drop;
  logic [2:0]    stale_cnt;
`ifdef IFU_PC_GEN_PERF_EN
  logic [31:0]   perf_drop_cnt;
`endif

  ifu_pc_gen_if #(.AW(AW)) bus_if ();

  ifu_pc_gen #(.AW(AW), .RESET_PC(32'h0), .FIFO_DEPTH(16), .MAX_OUTSTANDING(MAX)) dut (
    .i_clk         (clk),
    .i_rstn        (rstn),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .i_stall       (stall),
    .bus           (bus_if),
    .o_fifo_wen    (fifo_wen),
    .o_fifo_wdata  (fifo_wdata),
    .o_fifo_flush  (fifo_flush),
    .i_fifo_cnt    (fifo_cnt),
    .o_rsp_accept  (rsp_accept),
    .o_rsp_drop    (rsp_drop),
    .o_stale_cnt   (stale_cnt)
`ifdef IFU_PC_GEN_PERF_EN
    ,
    .o_perf_drop_cnt (perf_drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    int            epoch;
  } req_t;

  // Reference model state
  req_t          out_q[$];
  int            m_epoch;
  logic [AW-1:0] m_pc;
  bit            m_pending;
  bit            m_boot;
  bit            m_hold;
  int unsigned   m_perf;

  // Environment: address FIFO and bus response queue
  logic [AW-1:0] fifo_q[$];
  logic [AW-1:0] bus_q[$];

  int checks = 0;
  int errors = 0;

  // Sampled DUT outputs from the latest step
  logic          s_valid, s_wen, s_flush, s_accept, s_drop;
  logic [AW-1:0] s_addr;
  logic [2:0]    s_stale;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    out_q.delete();
    fifo_q.delete();
    bus_q.delete();
    m_epoch   = 0;
    m_pc      = 32'h0;
    m_pending = 0;
    m_boot    = 1;
    m_hold    = 0;
    m_perf    = 0;
  endtask

  // One clock cycle: drive inputs, compare all outputs with the model, then
  // advance model and environment to the next cycle. Entered at posedge+1.
  task automatic step(input bit rd, input logic [AW-1:0] rpc, input bit st,
                      input bit rdy, input bit rsp);
    bit            e_valid, e_wen, e_accept, e_drop, head_stale, old_pending;
    logic [AW-1:0] e_addr, aligned;
    int            e_stale;

    redirect          = rd;
    redirect_pc       = rpc;
    stall             = st;
    bus_if.req_ready  = rdy;
    bus_if.rsp_valid  = rsp;
    fifo_cnt          = 5'(fifo_q.size());
    #3;

    aligned  = {rpc[AW-1:2], 2'b00};
    e_valid  = !m_boot && !m_hold && (m_pending || (!st && out_q.size() < MAX));
    e_addr   = rd ? aligned : m_pc;
    e_wen    = e_valid && rdy;
    head_stale = rd || (out_q.size() > 0 && out_q[0].epoch != m_epoch);
    e_drop   = rsp && head_stale;
    e_accept = rsp && !head_stale;
    e_stale  = 0;
    foreach (out_q[i]) if (out_q[i].epoch != m_epoch) e_stale++;

    s_valid  = bus_if.req_valid;
    s_addr   = bus_if.req_addr;
    s_wen    = fifo_wen;
    s_flush  = fifo_flush;
    s_accept = rsp_accept;
    s_drop   = rsp_drop;
    s_stale  = stale_cnt;

    chk("req_valid", s_valid, e_valid);
    chk("req_addr", s_addr, e_addr);
    chk("fifo_wen", s_wen, e_wen);
    if (e_wen) chk("fifo_wdata", fifo_wdata, e_addr);
    chk("fifo_flush", s_flush, rd);
    chk("rsp_accept", s_accept, e_accept);
    chk("rsp_drop", s_drop, e_drop);
    chk("stale_cnt", s_stale, e_stale);
`ifdef IFU_PC_GEN_PERF_EN
    chk("perf_drop_cnt", perf_drop_cnt, m_perf);
`endif

    // Model advance
    old_pending = m_pending;
    if (rsp && out_q.size() > 0) void'(out_q.pop_front());
    if (rd) m_epoch++;
    if (e_wen) begin
      out_q.push_back('{addr: e_addr, epoch: m_epoch});
      m_pc      = e_addr + 32'd4;
      m_pending = 0;
    end else begin
      if (e_valid) m_pending = 1;
      if (rd) m_pc = aligned;
    end
    if (m_boot) m_boot = 0;
    else if (!m_hold && st && !old_pending) m_hold = 1;
    else if (m_hold && !st) m_hold = 0;
    if (e_drop && m_perf != 32'hFFFF_FFFF) m_perf++;

    // Environment advance, driven by what the DUT actually did
    if (rsp && bus_q.size() > 0) void'(bus_q.pop_front());
    if (fifo_wen) bus_q.push_back(fifo_wdata);
    if (rsp_accept && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (fifo_flush) fifo_q.delete();
    if (fifo_wen && fifo_q.size() < 16) fifo_q.push_back(fifo_wdata);

    @(posedge clk);
    #1;
  endtask

  task automatic random_phase(input int n);
    bit rd, st, rdy, rsp;
    for (int i = 0; i < n; i++) begin
      rd  = ($urandom_range(0, 99) < 6);
      st  = ($urandom_range(0, 99) < 20);
      rdy = ($urandom_range(0, 99) < 65);
      rsp = (bus_q.size() > 0) && ($urandom_range(0, 99) < 45);
      step(rd, $urandom, st, rdy, rsp);
    end
  endtask

  initial begin
    rstn             = 1'b0;
    redirect         = 1'b0;
    redirect_pc      = '0;
    stall            = 1'b0;
    bus_if.req_ready = 1'b0;
    bus_if.rsp_valid = 1'b0;
    fifo_cnt         = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Boot cycle, then four back-to-back pushes, then the outstanding limit
    step(0, 0, 0, 1, 0);
    chk("boot_valid", s_valid, 0);
    chk("boot_stale", s_stale, 0);
    chk("boot_wen", s_wen, 0);
    chk("boot_rsp", {s_accept, s_drop, s_flush}, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0);
      chk("seq_addr", s_addr, 32'(i * 4));
      chk("seq_wen", s_wen, 1);
    end
    step(0, 0, 0, 1, 0);
    chk("limit_valid", s_valid, 0);

    // One accept frees a slot; request 0x10 held through ready=0 and stall
    step(0, 0, 0, 0, 1);
    chk("first_accept", s_accept, 1);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, (i != 0), 0, 0);
      chk("hold_valid", s_valid, 1);
      chk("hold_addr", s_addr, 32'h10);
      chk("hold_wen", s_wen, 0);
    end
    step(0, 0, 1, 1, 0);
    chk("hold_push", {s_wen, s_addr}, {1'b1, 32'h10});
    step(0, 0, 1, 0, 1);
    chk("stall_no_issue", s_valid, 0);
    step(0, 0, 0, 0, 0);
    chk("hold_exit_gap", s_valid, 0);

    // Redirect with handshake while 3 are outstanding
    step(1, 32'h1002, 0, 1, 0);
    chk("redir_flush", s_flush, 1);
    chk("redir_wen", s_wen, 1);
    chk("redir_addr", s_addr, 32'h1000);
    step(0, 0, 0, 0, 1);
    chk("redir_stale", s_stale, 3);
    chk("redir_next_addr", s_addr, 32'h1004);
    chk("stale_drop0", s_drop, 1);
    step(0, 0, 0, 0, 1);
    chk("stale_cnt1", {s_stale, s_drop}, {3'd2, 1'b1});
    step(0, 0, 0, 0, 1);
    chk("stale_cnt2", {s_stale, s_drop}, {3'd1, 1'b1});
    step(0, 0, 0, 0, 1);
    chk("stale_done", {s_stale, s_accept}, {3'd0, 1'b1});

    // Build stale=1, fifo=2, then redirect with a response in the same cycle
    step(0, 0, 0, 1, 0);
    step(1, 32'h2000, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(1, 32'h3000, 0, 0, 1);
    chk("redir_rsp_stale_in", s_stale, 1);
    chk("redir_rsp_drop", {s_drop, s_accept}, {1'b1, 1'b0});
    step(0, 0, 0, 0, 0);
    chk("redir_rsp_stale_out", s_stale, 2);
`ifdef IFU_PC_GEN_PERF_EN
    chk("perf_literal", perf_drop_cnt, 32'd4);
`endif

    random_phase(1500);

    // Asynchronous reset in the middle of traffic
    redirect         = 1'b0;
    stall            = 1'b0;
    bus_if.req_ready = 1'b1;
    bus_if.rsp_valid = 1'b0;
    rstn             = 1'b0;
    #2;
    chk("midrst_valid", bus_if.req_valid, 0);
    chk("midrst_stale", stale_cnt, 0);
    chk("midrst_addr", bus_if.req_addr, 32'h0);
    model_reset();
    fifo_cnt = '0;
    @(posedge clk);
    #1;
    rstn = 1'b1;

    random_phase(1500);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
